vector_result_streamer: RTL and testbench
=========================================

Name: vector_result_streamer

Overview:
Consumer end of the vector multiplier's output interface. Captures one flat element-wise result vector plus its dot product on a load pulse. Streams the elements out one per handshake over a valid/ready interface, element 0 first, optionally followed by the dot product word. Sits between the multiplier and any narrow downstream sink (UART framer, FIFO, memory writer).

Parameters:
VECTOR_SIZE, 8, number of elements per vector (>= 2)
ELEMENT_SIZE, 16, bits per element and per dot-product word
IDX_W, $clog2(VECTOR_SIZE), element index width (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
load  input  1  capture request for result_in/dot_in
result_in  input  ELEMENT_SIZE*VECTOR_SIZE  flat result vector; element i at [i*ELEMENT_SIZE +: ELEMENT_SIZE]
dot_in  input  ELEMENT_SIZE  dot product accompanying result_in
busy  output  1  capture held and not fully streamed
load_drop  output  1  one-cycle pulse: load ignored because busy
out_data  output  ELEMENT_SIZE  current word
out_index  output  IDX_W  element index of out_data (0 during dot word)
out_is_dot  output  1  out_data is the dot product
out_valid  output  1  out_data valid
out_ready  input  1  sink accepts word when out_valid & out_ready
out_last  output  1  final word of this vector
done  output  1  one-cycle pulse in the cycle after the final transfer

Behaviour:
- Reset (async assert, sync deassert by the system): all outputs 0; state IDLE; capture registers 0.
- States: IDLE, ELEM, DOT.
- IDLE: busy=0, out_valid=0. load=1 -> capture result_in/dot_in into shadow registers, index=0, go to ELEM.
- ELEM: out_valid=1, out_data = captured element[index], out_index=index.
  - On transfer with index < VECTOR_SIZE-1: index+1.
  - On transfer with index = VECTOR_SIZE-1: go to DOT.
- DOT: out_valid=1, out_data=captured dot, out_is_dot=1, out_last=1. Transfer -> IDLE, done=1 next cycle.
- Latency: load in cycle N -> out_valid=1 with element 0 in cycle N+1. Back-to-back sink (out_ready=1) -> one word per cycle, VECTOR_SIZE+1 words total.
- Registered outputs: out_data, out_index, out_is_dot, out_last and out_valid stay stable while out_valid & !out_ready.
- load during busy -> ignored, capture unchanged, load_drop=1 next cycle.
- Exception: load in the same cycle as the final transfer is accepted, with no IDLE gap. New element 0 is valid in the next cycle, and done pulses in that same cycle.
- Inputs result_in/dot_in are sampled only at accepted load; later changes have no effect.
- rst mid-stream: immediate return to IDLE, outputs 0, partial stream discarded. The next load starts at element 0.
- No arithmetic; the index counter never exceeds VECTOR_SIZE-1 (no wrap).

Optional Feature:
VSTREAM_DOT_WORD_EN
- Defined: DOT state present; the stream is VECTOR_SIZE+1 words, with out_last on the dot word.
- Undefined: no DOT state. The final transfer goes from ELEM directly to IDLE, and out_last=1 on element VECTOR_SIZE-1. dot_in is not captured (port remains); out_is_dot is tied 0.

Decomposition:
- Shared package vec_pkg: default VECTOR_SIZE/ELEMENT_SIZE constants, state enum (IDLE/ELEM/DOT), index-width helper function shared with vector_multiplier users.
- No sub-module: the slice mux and FSM are small enough to live in one module.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 asynchronously, before the next clk edge.
- Elements 1..8, dot=0x00CC, out_ready=1: load at cycle 0 -> words 1,2,...,8 then 0x00CC in cycles 1..9. out_last only in cycle 9, done in cycle 10, busy=0 in cycle 10.
- Same vector, out_ready pattern 1,0,0,1,...: exactly 9 transfers in order. out_data held unchanged on every ready=0 cycle.
- Second load (elements 0xFFFF) at cycle 3 of a stream -> load_drop pulse at cycle 4. Stream still delivers 1..8, 0x00CC.
- load asserted in cycle 9 (final transfer) with elements 0x10..0x17 -> cycle 10 out_valid=1, out_data=0x0010, done=1.
- rst pulse after 3 transfers, then load -> first word out is element 0. With VSTREAM_DOT_WORD_EN undefined: 8 transfers, out_last on value 8.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared constants, state encoding and index-width helper for the vector multiplier slice.
// Combinational definitions only; no timing or backpressure of its own.
package vec_pkg;

   localparam int VEC_SIZE_DEF  = 8;
   localparam int ELEM_SIZE_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ELEM = 2'd1,
      ST_DOT  = 2'd2
   } vs_state_e;

   // Never returns 0, so an index bus is always at least one bit wide.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/vector_result_streamer.sv
// Captures a result vector (+ dot word when VSTREAM_DOT_WORD_EN) on load, streams one word per handshake.
// Latency: load in cycle N gives element 0 valid in cycle N+1; a stalled sink holds every output stable.
// Loads while busy are dropped with a pulse; a load in the final-transfer cycle chains with no idle gap.
module vector_result_streamer
   import vec_pkg::*;
#(
   parameter  int VECTOR_SIZE  = VEC_SIZE_DEF,
   parameter  int ELEMENT_SIZE = ELEM_SIZE_DEF,
   localparam int IDX_W        = idx_width(VECTOR_SIZE)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 load,
   input  logic [ELEMENT_SIZE*VECTOR_SIZE-1:0]  result_in,
   input  logic [ELEMENT_SIZE-1:0]              dot_in,
   output logic                                 busy,
   output logic                                 load_drop,
   output logic [ELEMENT_SIZE-1:0]              out_data,
   output logic [IDX_W-1:0]                     out_index,
   output logic                                 out_is_dot,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic                                 out_last,
   output logic                                 done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_SIZE - 1);

   vs_state_e                               state_q, state_d;
   logic [IDX_W-1:0]                        idx_q, idx_d;
   logic [ELEMENT_SIZE*VECTOR_SIZE-1:0]     cap_q, cap_d;
   logic [ELEMENT_SIZE-1:0]                 data_q, data_d;
   logic                                    valid_q, valid_d;
   logic                                    last_q, last_d;
   logic                                    drop_q, drop_d;
   logic                                    done_q, done_d;
   logic                                    xfer, final_xfer, accept;

`ifdef VSTREAM_DOT_WORD_EN
   logic [ELEMENT_SIZE-1:0]                 dot_q, dot_d;
   logic                                    isdot_q, isdot_d;
`else
   logic                                    unused_dot;
   assign unused_dot = ^dot_in;
`endif

   function automatic logic [ELEMENT_SIZE-1:0] elem_at(
      input logic [ELEMENT_SIZE*VECTOR_SIZE-1:0] v,
      input logic [IDX_W-1:0]                    i
   );
      elem_at = '0;
      for (int k = 0; k < VECTOR_SIZE; k++) begin
         if (i == IDX_W'(k)) elem_at = v[k*ELEMENT_SIZE +: ELEMENT_SIZE];
      end
   endfunction

   always_comb begin
      xfer       = valid_q & out_ready;
      final_xfer = xfer & last_q;
      accept     = load & ((state_q == ST_IDLE) | final_xfer);

      state_d = state_q;
      idx_d   = idx_q;
      cap_d   = cap_q;
      drop_d  = load & ~accept;
      done_d  = final_xfer;
`ifdef VSTREAM_DOT_WORD_EN
      dot_d   = dot_q;
`endif

      if (accept) begin
         cap_d   = result_in;
`ifdef VSTREAM_DOT_WORD_EN
         dot_d   = dot_in;
`endif
         idx_d   = '0;
         state_d = ST_ELEM;
      end else if (xfer) begin
         case (state_q)
            ST_ELEM: begin
               if (idx_q == LAST_IDX) begin
`ifdef VSTREAM_DOT_WORD_EN
                  state_d = ST_DOT;
`else
                  state_d = ST_IDLE;
`endif
                  idx_d = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // Outputs are decoded from the next state so they can be registered.
      data_d  = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
`ifdef VSTREAM_DOT_WORD_EN
      isdot_d = 1'b0;
`endif
      case (state_d)
         ST_ELEM: begin
            valid_d = 1'b1;
            data_d  = elem_at(cap_d, idx_d);
`ifndef VSTREAM_DOT_WORD_EN
            last_d  = (idx_d == LAST_IDX);
`endif
         end
`ifdef VSTREAM_DOT_WORD_EN
         ST_DOT: begin
            valid_d = 1'b1;
            data_d  = dot_d;
            last_d  = 1'b1;
            isdot_d = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         cap_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         drop_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef VSTREAM_DOT_WORD_EN
         dot_q   <= '0;
         isdot_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cap_q   <= cap_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         drop_q  <= drop_d;
         done_q  <= done_d;
`ifdef VSTREAM_DOT_WORD_EN
         dot_q   <= dot_d;
         isdot_q <= isdot_d;
`endif
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign load_drop = drop_q;
   assign out_data  = data_q;
   assign out_index = idx_q;
   assign out_valid = valid_q;
   assign out_last  = last_q;
   assign done      = done_q;
`ifdef VSTREAM_DOT_WORD_EN
   assign out_is_dot = isdot_q;
`else
   assign out_is_dot = 1'b0;
`endif

endmodule

// File: tb/tb_vector_result_streamer.sv
// Scoreboard bench for vector_result_streamer: expected words queued at load, popped by a monitor.
module tb_vector_result_streamer;

   localparam int VS = 8;
   localparam int ES = 16;
   localparam int IW = $clog2(VS);
`ifdef VSTREAM_DOT_WORD_EN
   localparam bit DOT_EN = 1'b1;
`else
   localparam bit DOT_EN = 1'b0;
`endif
   localparam int NWORDS = VS + (DOT_EN ? 1 : 0);

   typedef struct {
      int data;
      int idx;
      int is_dot;
      int last;
   } word_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              load;
   logic [ES*VS-1:0]  result_in;
   logic [ES-1:0]     dot_in;
   logic              busy, load_drop, out_is_dot, out_valid, out_ready, out_last, done;
   logic [ES-1:0]     out_data;
   logic [IW-1:0]     out_index;

   word_t exp_q[$];
   word_t mon_w;
   int    checks = 0;
   int    errors = 0;

   vector_result_streamer #(.VECTOR_SIZE(VS), .ELEMENT_SIZE(ES)) dut (
      .clk(clk), .rst(rst), .load(load), .result_in(result_in), .dot_in(dot_in),
      .busy(busy), .load_drop(load_drop), .out_data(out_data), .out_index(out_index),
      .out_is_dot(out_is_dot), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [ES*VS-1:0] mkvec(input int base, input int step);
      logic [ES*VS-1:0] v;
      v = '0;
      for (int i = 0; i < VS; i++) v[i*ES +: ES] = ES'(base + i*step);
      return v;
   endfunction

   task automatic push_vec(input int base, input int step, input int dot);
      word_t w;
      for (int i = 0; i < VS; i++) begin
         w.data   = (base + i*step) & 16'hFFFF;
         w.idx    = i;
         w.is_dot = 0;
         w.last   = (!DOT_EN && i == VS-1) ? 1 : 0;
         exp_q.push_back(w);
      end
      if (DOT_EN) begin
         w.data = dot; w.idx = 0; w.is_dot = 1; w.last = 1;
         exp_q.push_back(w);
      end
   endtask

   // Drives load for one cycle; only loads expected to be accepted are queued.
   task automatic do_load(input int base, input int step, input int dot, input bit expect_accept);
      result_in = mkvec(base, step);
      dot_in    = ES'(dot);
      load      = 1'b1;
      if (expect_accept) push_vec(base, step, dot);
      tick();
      load = 1'b0;
   endtask

   task automatic drain(input string name);
      int c;
      c = 0;
      while ((exp_q.size() != 0 || busy) && c < 200) begin
         tick();
         c++;
      end
      chk({name, "_drained"}, exp_q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got data 0x%0h, required no transfer", out_data);
         end else begin
            mon_w = exp_q.pop_front();
            chk("word_data",   int'(out_data),   mon_w.data);
            chk("word_index",  int'(out_index),  mon_w.idx);
            chk("word_is_dot", int'(out_is_dot), mon_w.is_dot);
            chk("word_last",   int'(out_last),   mon_w.last);
         end
      end
   end

   initial begin
      int  c;
      bit  stalled;
      logic [ES-1:0] held;
      bit  pat [3];
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;

      rst = 1'b1; load = 1'b0; out_ready = 1'b0;
      result_in = '0; dot_in = '0;
      #3;
      chk("reset_valid", int'(out_valid), 0);
      chk("reset_busy",  int'(busy), 0);
      chk("reset_data",  int'(out_data), 0);
      chk("reset_done",  int'(done), 0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // Back-to-back sink: one word per cycle, last on final word, done one cycle later.
      out_ready = 1'b1;
      do_load(1, 1, 16'h00CC, 1'b1);
      chk("t2_busy_c1", int'(busy), 1);
      for (int w = 0; w < NWORDS; w++) begin
         chk("t2_valid", int'(out_valid), 1);
         chk("t2_last",  int'(out_last), (w == NWORDS-1) ? 1 : 0);
         chk("t2_done_early", int'(done), 0);
         tick();
      end
      chk("t2_done",  int'(done), 1);
      chk("t2_busy_end", int'(busy), 0);
      chk("t2_valid_end", int'(out_valid), 0);
      tick();
      chk("t2_done_pulse", int'(done), 0);
      chk("t2_queue", exp_q.size(), 0);

      // Ready pattern 1,0,0: outputs held while stalled.
      do_load(1, 1, 16'h00CC, 1'b1);
      c = 0;
      while ((exp_q.size() != 0 || busy) && c < 200) begin
         out_ready = pat[c % 3];
         stalled = out_valid && !out_ready;
         held = out_data;
         tick();
         c++;
         if (stalled) begin
            chk("t3_hold_valid", int'(out_valid), 1);
            chk("t3_hold_data",  int'(out_data), int'(held));
         end
      end
      chk("t3_drained", exp_q.size(), 0);
      out_ready = 1'b1;
      tick();

      // Load during busy is dropped.
      do_load(1, 1, 16'h00CC, 1'b1);
      tick(); tick();
      do_load(16'hFFFF, 0, 16'hFFFF, 1'b0);
      chk("t4_drop", int'(load_drop), 1);
      tick();
      chk("t4_drop_pulse", int'(load_drop), 0);
      drain("t4");
      tick();

      // Load coinciding with the final transfer chains with no gap.
      do_load(1, 1, 16'h00CC, 1'b1);
      for (int w = 0; w < NWORDS-1; w++) tick();
      chk("t5_last_before", int'(out_last), 1);
      do_load(16'h10, 1, 16'h0055, 1'b1);
      chk("t5_valid", int'(out_valid), 1);
      chk("t5_data",  int'(out_data), 16'h0010);
      chk("t5_index", int'(out_index), 0);
      chk("t5_done",  int'(done), 1);
      drain("t5");
      tick();

      // Reset mid-stream discards the rest; next load restarts at element 0.
      do_load(1, 1, 16'h00CC, 1'b1);
      tick(); tick(); tick();
      chk("t6_remaining", exp_q.size(), NWORDS-3);
      #1;
      rst = 1'b1;
      exp_q.delete();
      #1;
      chk("t6_rst_valid", int'(out_valid), 0);
      chk("t6_rst_busy",  int'(busy), 0);
      chk("t6_rst_data",  int'(out_data), 0);
      tick();
      rst = 1'b0;
      tick();
      do_load(1, 1, 16'h00CC, 1'b1);
      chk("t6_first", int'(out_data), 1);
      drain("t6");
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
